// File: rtl/safe_wrapper_fsm.sv
// Sequencing FSM of the safe CPU wrapper: halts the cores via debug
// request, optionally runs a master-first context sync, releases them into
// a lockstep or single-core run, and supervises mismatches and timeouts.
module safe_wrapper_fsm #(
    parameter int unsigned HALT_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [2:0] master_core_i,
    input  logic       safe_mode_i,
    input  logic [1:0] safe_configuration_i,
    input  logic       critical_section_i,
    input  logic       initial_sync_master_i,
    input  logic       end_sw_routine_i,
    input  logic [2:0] core_halted_i,
    input  logic       mismatch_i,
    output logic [2:0] debug_req_o,
    output logic [2:0] resume_o,
    output logic [2:0] core_active_o,
    output logic       lockstep_en_o,
    output logic       tmr_mode_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [1:0] error_cause_o,
    output logic [7:0] mismatch_cnt_o
);

    localparam int unsigned TW = $clog2(HALT_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_SYNC_REL,
        S_SYNC_WAIT,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic          start_q, end_q;
    logic [2:0]    master_q, mask_q, mask_new;
    logic          sync_q;
    logic [1:0]    cause_q, cause_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q;

    logic start_rise, end_rise, master_onehot, cfg_bad, launch;
    logic multi_core, timeout, count_mm;

    assign start_rise    = start_i & ~start_q;
    assign end_rise      = end_sw_routine_i & ~end_q;
    assign master_onehot = (master_core_i == 3'b001) || (master_core_i == 3'b010) ||
                           (master_core_i == 3'b100);
    assign cfg_bad       = ~master_onehot | (safe_mode_i & (safe_configuration_i == 2'b11));
    assign launch        = (state_q == S_IDLE) & start_rise;
    // At least two participating cores means the voter has something to compare.
    assign multi_core    = (mask_q[0] & mask_q[1]) | (mask_q[0] & mask_q[2]) |
                           (mask_q[1] & mask_q[2]);
    assign timeout       = (tmo_q == TW'(HALT_TIMEOUT - 1));
    assign count_mm      = mismatch_i & multi_core;

    // Participating-core mask derived from the live configuration at launch.
    always_comb begin
        mask_new = master_core_i;
        if (safe_mode_i) begin
            case (safe_configuration_i)
                2'b01:   mask_new = master_core_i | {master_core_i[1:0], master_core_i[2]};
                2'b10:   mask_new = 3'b111;
                default: mask_new = master_core_i;
            endcase
        end
    end

    // Next-state logic plus the cause and mismatch-count updates.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        if ((state_q != S_IDLE) && !start_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        if (cfg_bad) begin
                            state_d = S_ERROR;
                            cause_d = 2'b01;
                        end else begin
                            state_d = S_HALT;
                            cause_d = 2'b00;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                S_HALT: begin
                    if ((core_halted_i & mask_q) == mask_q) begin
                        state_d = sync_q ? S_SYNC_REL : S_RELEASE;
                    end else if (timeout) begin
                        state_d = S_ERROR;
                        cause_d = 2'b10;
                    end
                end
                S_SYNC_REL: state_d = S_SYNC_WAIT;
                S_SYNC_WAIT: begin
                    if (|(core_halted_i & master_q)) begin
                        state_d = S_RELEASE;
                    end else if (timeout) begin
                        state_d = S_ERROR;
                        cause_d = 2'b11;
                    end
                end
                S_RELEASE: state_d = S_RUN;
                S_RUN: begin
                    if (count_mm && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (end_rise) begin
                        state_d = S_DONE;
                    end else if (count_mm && critical_section_i) begin
                        state_d = S_HALT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State, edge-detect samples, status and wait-state timeout counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            cause_q <= 2'b00;
            cnt_q   <= 8'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            end_q   <= end_sw_routine_i;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if ((state_q == S_HALT) || (state_q == S_SYNC_WAIT)) begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    // Shadow configuration captured on each launch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            master_q <= 3'b000;
            mask_q   <= 3'b000;
            sync_q   <= 1'b0;
        end else if (launch) begin
            master_q <= master_core_i;
            mask_q   <= mask_new;
            sync_q   <= initial_sync_master_i;
        end
    end

    // Outputs decoded from registered state and shadow registers.
    always_comb begin
        debug_req_o    = 3'b000;
        resume_o       = 3'b000;
        core_active_o  = 3'b000;
        lockstep_en_o  = 1'b0;
        tmr_mode_o     = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        error_o        = 1'b0;
        error_cause_o  = cause_q;
        mismatch_cnt_o = cnt_q;
        if (state_q != S_IDLE) core_active_o = mask_q;
        case (state_q)
            S_HALT: begin
                debug_req_o = mask_q & ~core_halted_i;
                busy_o      = 1'b1;
            end
            S_SYNC_REL: begin
                resume_o = master_q;
                busy_o   = 1'b1;
            end
            S_SYNC_WAIT: busy_o = 1'b1;
            S_RELEASE: begin
                resume_o = mask_q;
                busy_o   = 1'b1;
            end
            S_RUN: begin
                lockstep_en_o = multi_core;
                tmr_mode_o    = (mask_q == 3'b111);
                busy_o        = 1'b1;
            end
            S_DONE:  done_o  = 1'b1;
            S_ERROR: error_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_safe_wrapper_fsm.sv
// Bench for safe_wrapper_fsm: a phase-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_safe_wrapper_fsm;

    localparam int TMO = 16;
    localparam int P_IDLE = 0, P_HALT = 1, P_SREL = 2, P_SWAIT = 3,
                   P_REL = 4, P_RUN = 5, P_DONE = 6, P_ERR = 7;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] master_core_i = 3'b000;
    logic       safe_mode_i = 1'b0;
    logic [1:0] safe_configuration_i = 2'b00;
    logic       critical_section_i = 1'b0;
    logic       initial_sync_master_i = 1'b0;
    logic       end_sw_routine_i = 1'b0;
    logic [2:0] core_halted_i = 3'b000;
    logic       mismatch_i = 1'b0;
    logic [2:0] debug_req_o, resume_o, core_active_o;
    logic       lockstep_en_o, tmr_mode_o, busy_o, done_o, error_o;
    logic [1:0] error_cause_o;
    logic [7:0] mismatch_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    safe_wrapper_fsm #(.HALT_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .master_core_i(master_core_i), .safe_mode_i(safe_mode_i),
        .safe_configuration_i(safe_configuration_i),
        .critical_section_i(critical_section_i),
        .initial_sync_master_i(initial_sync_master_i),
        .end_sw_routine_i(end_sw_routine_i), .core_halted_i(core_halted_i),
        .mismatch_i(mismatch_i), .debug_req_o(debug_req_o), .resume_o(resume_o),
        .core_active_o(core_active_o), .lockstep_en_o(lockstep_en_o),
        .tmr_mode_o(tmr_mode_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .error_cause_o(error_cause_o),
        .mismatch_cnt_o(mismatch_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [2:0] mask_of(input logic [2:0] m, input logic safe,
                                           input logic [1:0] cfg);
        logic [2:0] partner;
        partner = (m << 1) | (m >> 2);
        if (!safe || cfg == 2'b00 || cfg == 2'b11) return m;
        if (cfg == 2'b01) return m | partner;
        return 3'b111;
    endfunction

    // Behavioural model state
    int         m_ph, m_cnt, m_cyc;
    logic [2:0] m_master, m_mask;
    logic       m_sync, m_sp, m_ep;
    logic [1:0] m_cause;
    logic       s_rise, e_rise, m_multi;

    assign s_rise  = start_i & ~m_sp;
    assign e_rise  = end_sw_routine_i & ~m_ep;
    assign m_multi = ($countones(m_mask) > 1);

    // Model: advances one phase step per clock from the behavioural rules
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_ph <= P_IDLE; m_cnt <= 0; m_cyc <= 0; m_master <= 3'b000;
            m_mask <= 3'b000; m_sync <= 1'b0; m_sp <= 1'b0; m_ep <= 1'b0;
            m_cause <= 2'b00;
        end else begin
            m_sp <= start_i;
            m_ep <= end_sw_routine_i;
            if (m_ph != P_IDLE && !start_i) begin
                m_ph <= P_IDLE;
            end else begin
                case (m_ph)
                    P_IDLE: if (s_rise) begin
                        m_master <= master_core_i;
                        m_mask   <= mask_of(master_core_i, safe_mode_i, safe_configuration_i);
                        m_sync   <= initial_sync_master_i;
                        if ($countones(master_core_i) != 1 ||
                            (safe_mode_i && safe_configuration_i == 2'b11)) begin
                            m_ph <= P_ERR; m_cause <= 2'b01;
                        end else begin
                            m_ph <= P_HALT; m_cause <= 2'b00; m_cnt <= 0; m_cyc <= 0;
                        end
                    end
                    P_HALT: begin
                        m_cyc <= m_cyc + 1;
                        if ((core_halted_i & m_mask) == m_mask) m_ph <= m_sync ? P_SREL : P_REL;
                        else if (m_cyc + 1 == TMO) begin m_ph <= P_ERR; m_cause <= 2'b10; end
                    end
                    P_SREL: begin m_ph <= P_SWAIT; m_cyc <= 0; end
                    P_SWAIT: begin
                        m_cyc <= m_cyc + 1;
                        if ((core_halted_i & m_master) != 0) m_ph <= P_REL;
                        else if (m_cyc + 1 == TMO) begin m_ph <= P_ERR; m_cause <= 2'b11; end
                    end
                    P_REL: m_ph <= P_RUN;
                    P_RUN: begin
                        if (mismatch_i && m_multi && m_cnt < 255) m_cnt <= m_cnt + 1;
                        if (e_rise) m_ph <= P_DONE;
                        else if (mismatch_i && m_multi && critical_section_i) begin
                            m_ph <= P_HALT; m_cyc <= 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare: every cycle, shortly after the active edge
    always @(posedge clk) begin
        #1;
        chk("cmp_debug_req", debug_req_o, (m_ph == P_HALT) ? (m_mask & ~core_halted_i) : 3'b000);
        chk("cmp_resume", resume_o, (m_ph == P_SREL) ? m_master : (m_ph == P_REL) ? m_mask : 3'b000);
        chk("cmp_core_active", core_active_o, (m_ph != P_IDLE) ? m_mask : 3'b000);
        chk("cmp_lockstep", lockstep_en_o, (m_ph == P_RUN) && m_multi);
        chk("cmp_tmr", tmr_mode_o, (m_ph == P_RUN) && (m_mask == 3'b111));
        chk("cmp_busy", busy_o, (m_ph >= P_HALT) && (m_ph <= P_RUN));
        chk("cmp_done", done_o, m_ph == P_DONE);
        chk("cmp_error", error_o, m_ph == P_ERR);
        chk("cmp_cause", error_cause_o, m_cause);
        chk("cmp_cnt", mismatch_cnt_o, m_cnt);
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_busy", busy_o, 0);
        chk("rst_dbg", debug_req_o, 0);
        chk("rst_cnt", mismatch_cnt_o, 0);
        chk("rst_cause", error_cause_o, 0);
        rst_ni = 1'b1;
        step(2);

        // TMR, master 001, no sync
        master_core_i = 3'b001; safe_mode_i = 1'b1; safe_configuration_i = 2'b10;
        initial_sync_master_i = 1'b0; start_i = 1'b1;
        step(1);
        chk("t1_dbg", debug_req_o, 3'b111);
        chk("t1_active", core_active_o, 3'b111);
        step(2);
        core_halted_i = 3'b111;
        step(1);
        chk("t1_resume", resume_o, 3'b111);
        core_halted_i = 3'b000;
        step(1);
        chk("t1_resume_pulse", resume_o, 3'b000);
        chk("t1_lockstep", lockstep_en_o, 1);
        chk("t1_tmr", tmr_mode_o, 1);
        repeat (300) begin
            mismatch_i = 1'b1; step(1); mismatch_i = 1'b0; step(1);
        end
        chk("t1_cnt_sat", mismatch_cnt_o, 8'd255);
        chk("t1_still_run", lockstep_en_o, 1);
        mismatch_i = 1'b1; critical_section_i = 1'b1;
        step(1);
        mismatch_i = 1'b0; critical_section_i = 1'b0;
        chk("t1_resync_dbg", debug_req_o, 3'b111);
        chk("t1_resync_cnt", mismatch_cnt_o, 8'd255);
        core_halted_i = 3'b111; step(1);
        core_halted_i = 3'b000; step(1);
        chk("t1_rerun", lockstep_en_o, 1);
        start_i = 1'b0; step(1);
        chk("t1_abort_busy", busy_o, 0);
        chk("t1_abort_active", core_active_o, 3'b000);
        chk("t1_abort_cnt", mismatch_cnt_o, 8'd255);
        step(1);

        // DMR, master 100, master-first sync
        master_core_i = 3'b100; safe_configuration_i = 2'b01;
        initial_sync_master_i = 1'b1; start_i = 1'b1;
        step(1);
        chk("t2_active", core_active_o, 3'b101);
        chk("t2_dbg", debug_req_o, 3'b101);
        chk("t2_cnt_clr", mismatch_cnt_o, 0);
        core_halted_i = 3'b101; step(1);
        chk("t2_sync_resume", resume_o, 3'b100);
        core_halted_i = 3'b001; step(1);
        chk("t2_wait_resume", resume_o, 3'b000);
        step(2);
        core_halted_i = 3'b101; step(1);
        chk("t2_release", resume_o, 3'b101);
        core_halted_i = 3'b000; step(1);
        chk("t2_lockstep", lockstep_en_o, 1);
        chk("t2_dmr", tmr_mode_o, 0);
        repeat (3) begin
            mismatch_i = 1'b1; step(1); mismatch_i = 1'b0; step(1);
        end
        chk("t2_cnt3", mismatch_cnt_o, 3);
        mismatch_i = 1'b1; end_sw_routine_i = 1'b1;
        step(1);
        mismatch_i = 1'b0;
        chk("t2_done", done_o, 1);
        chk("t2_cnt4", mismatch_cnt_o, 4);
        step(1);
        chk("t2_done_hold", done_o, 1);
        start_i = 1'b0; end_sw_routine_i = 1'b0; step(1);
        chk("t2_done_clr", done_o, 0);

        // Invalid master select
        master_core_i = 3'b011; safe_mode_i = 1'b0; safe_configuration_i = 2'b00;
        initial_sync_master_i = 1'b0; start_i = 1'b1;
        step(1);
        chk("t3_error", error_o, 1);
        chk("t3_cause", error_cause_o, 2'b01);
        start_i = 1'b0; step(1);
        chk("t3_error_clr", error_o, 0);
        chk("t3_cause_kept", error_cause_o, 2'b01);

        // Halt timeout, single core 010
        master_core_i = 3'b010; core_halted_i = 3'b000; start_i = 1'b1;
        step(1);
        chk("t4_dbg", debug_req_o, 3'b010);
        step(TMO - 1);
        chk("t4_no_err_yet", error_o, 0);
        step(1);
        chk("t4_error", error_o, 1);
        chk("t4_cause", error_cause_o, 2'b10);
        start_i = 1'b0; step(1);

        // Sync timeout, DMR master 001
        master_core_i = 3'b001; safe_mode_i = 1'b1; safe_configuration_i = 2'b01;
        initial_sync_master_i = 1'b1; start_i = 1'b1;
        step(1);
        core_halted_i = 3'b011; step(1);
        chk("t5_sync_resume", resume_o, 3'b001);
        core_halted_i = 3'b000; step(1);
        step(TMO - 1);
        chk("t5_no_err_yet", error_o, 0);
        step(1);
        chk("t5_error", error_o, 1);
        chk("t5_cause", error_cause_o, 2'b11);
        start_i = 1'b0; step(1);

        // Asynchronous reset in the middle of a sequence
        master_core_i = 3'b001; safe_configuration_i = 2'b10;
        initial_sync_master_i = 1'b0; start_i = 1'b1;
        step(1);
        chk("t6_halt", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_dbg", debug_req_o, 0);
        chk("t6_rst_active", core_active_o, 0);
        chk("t6_rst_cause", error_cause_o, 0);
        @(negedge clk);
        start_i = 1'b0; rst_ni = 1'b1;
        step(2);
        chk("t6_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
